// File: rtl/uart_dac_cmd_rx.sv
// uart_dac_cmd_rx: UART receiver plus "DAC:dddd\n" line parser driving a DAC.
// Bytes are deserialised from uart_rx and parsed into a decimal value that is
// presented on dac_data with a one-cycle dac_valid strobe; bad lines pulse cmd_err.
// Optional build macro: UART_RX_PARITY_EN selects 8E1 frames (even parity);
// when it is undefined the receiver is plain 8N1 with no parity logic.
module uart_dac_cmd_rx #(
    parameter int CLK_FRE   = 50,       // system clock in MHz
    parameter int UART_RATE = 115200,   // baud rate
    parameter int DAC_W     = 12        // dac_data width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_rx,
    output logic [DAC_W-1:0] dac_data,
    output logic             dac_valid,
    output logic             cmd_err
);

    localparam int          BIT_CYC = CLK_FRE * 1_000_000 / UART_RATE;
    localparam int          HALF    = BIT_CYC / 2;
    localparam int          CNT_W   = $clog2(BIT_CYC + 1);
    localparam int unsigned DAC_MAX = (1 << DAC_W) - 1;

    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_D   = 8'h44;
    localparam logic [7:0] CH_A   = 8'h41;
    localparam logic [7:0] CH_C   = 8'h43;
    localparam logic [7:0] CH_COL = 8'h3A;
    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;

    // ------------------------------------------------------------------
    // Input synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    logic rx_meta, rx_sync, rx_prev;
    logic rx_fall;

    // Two flops bring uart_rx into the clk domain; a third remembers the last synced level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    // ------------------------------------------------------------------
    // Bit-level receive FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        B_IDLE  = 3'd0,
        B_START = 3'd1,
        B_DATA  = 3'd2,
        B_STOP  = 3'd3,
`ifdef UART_RX_PARITY_EN
        B_WAIT  = 3'd4,
        B_PAR   = 3'd5
`else
        B_WAIT  = 3'd4
`endif
    } bit_state_t;

    bit_state_t       b_st, b_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             half_tick, bit_tick;
    logic             smp_start, smp_data, smp_stop;
    logic             stop_done, stop_bit;
    logic             par_bad;
    logic             byte_stb, frame_err;
    logic [7:0]       byte_data;

    assign half_tick = (cnt == CNT_W'(HALF - 1));
    assign bit_tick  = (cnt == CNT_W'(BIT_CYC - 1));
    assign byte_data = shreg;

    // Bit FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) b_st <= B_IDLE;
        else     b_st <= b_nxt;
    end

    // Bit FSM next state: start qualified at mid-bit, LSB-first data, optional parity, stop.
    always_comb begin
        b_nxt = b_st;
        case (b_st)
            B_IDLE:  if (rx_fall) b_nxt = B_START;
            B_START: if (half_tick) b_nxt = rx_sync ? B_IDLE : B_DATA;
`ifdef UART_RX_PARITY_EN
            B_DATA:  if (bit_tick && bit_idx == 3'd7) b_nxt = B_PAR;
            B_PAR:   if (bit_tick) b_nxt = B_STOP;
`else
            B_DATA:  if (bit_tick && bit_idx == 3'd7) b_nxt = B_STOP;
`endif
            // A low stop bit means the line may still be low: wait for idle before rearming.
            B_STOP:  if (bit_tick) b_nxt = rx_sync ? B_IDLE : B_WAIT;
            B_WAIT:  if (rx_sync) b_nxt = B_IDLE;
            default: b_nxt = B_IDLE;
        endcase
    end

    // Bit FSM outputs: which sample point is being taken this cycle.
    always_comb begin
        smp_start = 1'b0;
        smp_data  = 1'b0;
        smp_stop  = 1'b0;
        case (b_st)
            B_START: smp_start = half_tick;
            B_DATA:  smp_data  = bit_tick;
            B_STOP:  smp_stop  = bit_tick;
            default: ;
        endcase
    end

    // Bit timer, data shifter and stop-bit capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'd0;
            stop_done <= 1'b0;
            stop_bit  <= 1'b1;
        end else begin
            // Timer restarts on every state change and every bit boundary; parked when idle.
            if (b_st == B_IDLE || b_st == B_WAIT || b_nxt != b_st || bit_tick)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
            if (smp_start)
                bit_idx <= 3'd0;
            if (smp_data) begin
                shreg   <= {rx_sync, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            stop_done <= smp_stop;
            if (smp_stop)
                stop_bit <= rx_sync;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic smp_par;
    assign smp_par = (b_st == B_PAR) && bit_tick;

    // Even parity: the received parity bit must equal the XOR of the data bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          par_bad <= 1'b0;
        else if (smp_par) par_bad <= (^shreg) ^ rx_sync;
    end
`else
    assign par_bad = 1'b0;
`endif

    // Byte strobe or frame error, one cycle after the stop bit was captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_stb  <= stop_done &  stop_bit & ~par_bad;
            frame_err <= stop_done & (~stop_bit | par_bad);
        end
    end

    // ------------------------------------------------------------------
    // Line parser FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        P0     = 3'd0,
        P1     = 3'd1,
        P2     = 3'd2,
        P3     = 3'd3,
        P_DIG  = 3'd4,
        P_DISC = 3'd5
    } parse_state_t;

    parse_state_t p_st, p_nxt;
    logic [13:0]  acc;        // up to 9999 before range check
    logic [13:0]  acc_next;
    logic [2:0]   ndig;
    logic         is_digit, is_lf, line_ok;
    logic         accept, reject, dig_en;

    assign is_digit = (byte_data >= CH_0) && (byte_data <= CH_9);
    // acc*10 + digit; acc is at most 999 whenever a digit is accumulated, so no overflow.
    assign acc_next = {acc[10:0], 3'b000} + {acc[12:0], 1'b0} + {10'd0, byte_data[3:0]};

    // Parser state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) p_st <= P0;
        else     p_st <= p_nxt;
    end

    // Parser next state: match the "DAC:" prefix, collect digits, resync on '\n'.
    always_comb begin
        p_nxt = p_st;
        if (frame_err) begin
            p_nxt = P_DISC;
        end else if (byte_stb) begin
            case (p_st)
                P0: begin
                    if (byte_data == CH_D)
                        p_nxt = P1;
                    else if (byte_data != CH_LF && byte_data != CH_CR)
                        p_nxt = P_DISC;
                end
                P1:     p_nxt = (byte_data == CH_A)   ? P2    : P_DISC;
                P2:     p_nxt = (byte_data == CH_C)   ? P3    : P_DISC;
                P3:     p_nxt = (byte_data == CH_COL) ? P_DIG : P_DISC;
                P_DIG: begin
                    if (is_digit)
                        p_nxt = (ndig == 3'd4) ? P_DISC : P_DIG;
                    else if (byte_data == CH_LF)
                        p_nxt = P0;
                    else if (byte_data != CH_CR)
                        p_nxt = P_DISC;
                end
                P_DISC: if (byte_data == CH_LF) p_nxt = P0;
                default: p_nxt = P0;
            endcase
        end
    end

    // Parser outputs: accept/reject decision on '\n' and digit accumulate enable.
    always_comb begin
        is_lf   = byte_stb && (byte_data == CH_LF);
        line_ok = (ndig != 3'd0) && (32'(acc) <= DAC_MAX);
        accept  = 1'b0;
        reject  = 1'b0;
        dig_en  = 1'b0;
        case (p_st)
            P_DIG: begin
                accept = is_lf &&  line_ok;
                reject = is_lf && !line_ok;
                dig_en = byte_stb && is_digit && (ndig != 3'd4);
            end
            P_DISC:  reject = is_lf;
            default: ;
        endcase
    end

    // Accumulator, digit count and registered result strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= 14'd0;
            ndig      <= 3'd0;
            dac_data  <= '0;
            dac_valid <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            dac_valid <= accept;
            cmd_err   <= reject;
            if (accept)
                dac_data <= acc[DAC_W-1:0];
            // Any entry to (or stay in) P0 starts the next line from a clean accumulator.
            if (p_nxt == P0) begin
                acc  <= 14'd0;
                ndig <= 3'd0;
            end else if (dig_en) begin
                acc  <= acc_next;
                ndig <= ndig + 3'd1;
            end
        end
    end

endmodule
